fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_pkg.sv | 12 +
 rtl/fwd_src_sel.sv | 62 ++++++
 rtl/fwd_hazard_unit.sv | 91 +++++++++
 tb/tb_fwd_hazard_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared encodings for the forwarding/hazard unit: source-select codes
// and the default width of the Tnew/Tuse fields.
package fwd_pkg;

  localparam int TW_DEF = 2;

  // src_sel codes: RF read, stage k forwarded as SEL_STG_OFS+k, deferred
  localparam logic [2:0] SEL_RF      = 3'd0;
  localparam logic [2:0] SEL_STG_OFS = 3'd1;
  localparam logic [2:0] SEL_DEFER   = 3'd7;

endpackage

// File: rtl/fwd_src_sel.sv
// Per-source producer search: finds the youngest in-flight writer of the
// source register and decides between forwarding, deferring or stalling.
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NSTG = 3,
  parameter int TW   = TW_DEF
) (
  input  logic [4:0]         src,
  input  logic [TW-1:0]      tuse,
  input  logic [DW-1:0]      rf_data,
  input  logic [NSTG*DW-1:0] stg_data,
  input  logic [NSTG-1:0]    ent_valid,
  input  logic [NSTG*5-1:0]  ent_a3,
  input  logic [NSTG*TW-1:0] ent_tnew,
  output logic               stall_req,
  output logic [2:0]         sel,
  output logic [DW-1:0]      data
);

  logic          hit;
  logic [TW-1:0] hit_tnew;
  logic [2:0]    hit_sel;
  logic [DW-1:0] hit_data;

  // Walk from oldest to youngest so the youngest matching entry wins;
  // writes to $0 never match since $0 is hardwired.
  always_comb begin
    hit      = 1'b0;
    hit_tnew = '0;
    hit_sel  = SEL_RF;
    hit_data = rf_data;
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (ent_valid[k] && (ent_a3[k*5 +: 5] != 5'd0) &&
          (ent_a3[k*5 +: 5] == src)) begin
        hit      = 1'b1;
        hit_tnew = ent_tnew[k*TW +: TW];
        hit_sel  = SEL_STG_OFS + 3'(k);
        hit_data = stg_data[k*DW +: DW];
      end
    end
  end

  // Ready results are forwarded now; late results are either waited for
  // (stall) or left to the consuming stage's own forwarding (defer).
  always_comb begin
    stall_req = 1'b0;
    sel       = SEL_RF;
    data      = rf_data;
    if (hit) begin
      if (hit_tnew == '0) begin
        sel  = hit_sel;
        data = hit_data;
      end else begin
        sel       = SEL_DEFER;
        stall_req = (hit_tnew > tuse);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Decode-stage forwarding and hazard unit: tracks in-flight writers with
// their remaining Tnew and resolves every decode source against them.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NSRC = 2,
  parameter int NSTG = 3,
  parameter int TW   = TW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               d_valid,
  input  logic [4:0]         d_a3,
  input  logic [TW-1:0]      d_tnew,
  input  logic [NSRC*5-1:0]  d_src,
  input  logic [NSRC*TW-1:0] d_tuse,
  input  logic [NSRC*DW-1:0] rf_data,
  input  logic [NSTG*DW-1:0] stg_data,
  input  logic               flush,
  output logic               stall,
  output logic [NSRC*DW-1:0] src_data,
  output logic [NSRC*3-1:0]  src_sel,
  output logic [15:0]        stall_cnt
);

  logic [NSTG-1:0]    ent_valid;
  logic [NSTG*5-1:0]  ent_a3;
  logic [NSTG*TW-1:0] ent_tnew;
  logic [NSRC-1:0]    stall_req;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  assign stall = |stall_req;

  // Tracking pipeline: entry 0 takes the decoded writer unless stalled or
  // flushed, older entries shift along with Tnew counting down to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_valid <= '0;
      ent_a3    <= '0;
      ent_tnew  <= '0;
    end else begin
      if (d_valid && !stall && !flush) begin
        ent_valid[0]     <= 1'b1;
        ent_a3[4:0]      <= d_a3;
        ent_tnew[TW-1:0] <= d_tnew;
      end else begin
        ent_valid[0]     <= 1'b0;
        ent_a3[4:0]      <= 5'd0;
        ent_tnew[TW-1:0] <= '0;
      end
      for (int k = 1; k < NSTG; k++) begin
        ent_valid[k]          <= ent_valid[k-1];
        ent_a3[k*5 +: 5]      <= ent_a3[(k-1)*5 +: 5];
        ent_tnew[k*TW +: TW]  <= dec_sat(ent_tnew[(k-1)*TW +: TW]);
      end
    end
  end

  // Saturating count of cycles spent stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'd0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_src_sel #(
      .DW   (DW),
      .NSTG (NSTG),
      .TW   (TW)
    ) u_src_sel (
      .src       (d_src[i*5 +: 5]),
      .tuse      (d_tuse[i*TW +: TW]),
      .rf_data   (rf_data[i*DW +: DW]),
      .stg_data  (stg_data),
      .ent_valid (ent_valid),
      .ent_a3    (ent_a3),
      .ent_tnew  (ent_tnew),
      .stall_req (stall_req[i]),
      .sel       (src_sel[i*3 +: 3]),
      .data      (src_data[i*DW +: DW])
    );
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: ordered vector table with a scoreboard queue,
// plus hand-written reset sequences.
module tb_fwd_hazard_unit;

  localparam logic [31:0] RF0   = 32'hA000_0000;
  localparam logic [31:0] RF1   = 32'hA111_1111;
  localparam logic [31:0] STG_E = 32'h0040_0008;
  localparam logic [31:0] STG_M = 32'h0000_0022;
  localparam logic [31:0] STG_W = 32'h0000_0011;

  logic        clk;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_a3;
  logic [1:0]  d_tnew;
  logic [9:0]  d_src;
  logic [3:0]  d_tuse;
  logic [63:0] rf_data;
  logic [95:0] stg_data;
  logic        flush;
  logic        stall;
  logic [63:0] src_data;
  logic [5:0]  src_sel;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        v;
    logic [4:0]  a3;
    logic [1:0]  tn;
    logic [4:0]  s0;
    logic [1:0]  u0;
    logic [4:0]  s1;
    logic [1:0]  u1;
    logic        fl;
    logic        e_stall;
    logic [2:0]  e_sel0;
    logic [2:0]  e_sel1;
    logic [3:0]  mask;   // bit0 stall, bit1 src0, bit2 src1, bit3 stall_cnt
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[26];
  vec_t sb[$];

  fwd_hazard_unit dut (
    .clk       (clk),
    .reset     (reset),
    .d_valid   (d_valid),
    .d_a3      (d_a3),
    .d_tnew    (d_tnew),
    .d_src     (d_src),
    .d_tuse    (d_tuse),
    .rf_data   (rf_data),
    .stg_data  (stg_data),
    .flush     (flush),
    .stall     (stall),
    .src_data  (src_data),
    .src_sel   (src_sel),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t row(logic v, logic [4:0] a3, logic [1:0] tn,
                               logic [4:0] s0, logic [1:0] u0,
                               logic [4:0] s1, logic [1:0] u1, logic fl,
                               logic es, logic [2:0] e0, logic [2:0] e1,
                               logic [3:0] m, logic [15:0] c);
    vec_t r;
    r.v = v; r.a3 = a3; r.tn = tn; r.s0 = s0; r.u0 = u0; r.s1 = s1;
    r.u1 = u1; r.fl = fl; r.e_stall = es; r.e_sel0 = e0; r.e_sel1 = e1;
    r.mask = m; r.e_cnt = c;
    return r;
  endfunction

  function automatic logic [31:0] exp_data(int i, logic [2:0] s);
    case (s)
      3'd1:    return STG_E;
      3'd2:    return STG_M;
      3'd3:    return STG_W;
      default: return (i == 0) ? RF0 : RF1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    d_valid = r.v;
    d_a3    = r.a3;
    d_tnew  = r.tn;
    d_src   = {r.s1, r.s0};
    d_tuse  = {r.u1, r.u0};
    flush   = r.fl;
    sb.push_back(r);
  endtask

  task automatic sample(input int idx);
    vec_t e;
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL r%0d_scoreboard: got empty queue, expected entry", idx);
      return;
    end
    e = sb.pop_front();
    if (e.mask[0]) check($sformatf("r%0d_stall", idx), 32'(stall), 32'(e.e_stall));
    if (e.mask[1]) begin
      check($sformatf("r%0d_sel0", idx), 32'(src_sel[2:0]), 32'(e.e_sel0));
      check($sformatf("r%0d_data0", idx), src_data[31:0], exp_data(0, e.e_sel0));
    end
    if (e.mask[2]) begin
      check($sformatf("r%0d_sel1", idx), 32'(src_sel[5:3]), 32'(e.e_sel1));
      check($sformatf("r%0d_data1", idx), src_data[63:32], exp_data(1, e.e_sel1));
    end
    if (e.mask[3]) check($sformatf("r%0d_cnt", idx), 32'(stall_cnt), 32'(e.e_cnt));
  endtask

  initial begin
    // lw $8 then dependent add: one stall, then deferred
    tbl[0]  = row(1,  8, 2, 29, 1,  0, 0, 0, 0, 0, 0, 4'hF, 0);
    tbl[1]  = row(1, 10, 1,  8, 1,  9, 1, 0, 1, 0, 0, 4'hD, 0);
    tbl[2]  = row(1, 10, 1,  8, 1,  9, 1, 0, 0, 7, 0, 4'hF, 1);
    tbl[3]  = row(0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 1);
    tbl[4]  = row(0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 1);
    tbl[5]  = row(0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 1);
    // addu $9 then beq $9: one stall, then forward from M
    tbl[6]  = row(1,  9, 1,  0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 1);
    tbl[7]  = row(1,  0, 0,  9, 0,  8, 0, 0, 1, 0, 0, 4'hD, 1);
    tbl[8]  = row(1,  0, 0,  9, 0,  8, 0, 0, 0, 2, 0, 4'hF, 2);
    // jal $31 then jr $31: forward PC+8 from E
    tbl[9]  = row(1, 31, 0,  0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 2);
    tbl[10] = row(1,  0, 0, 31, 0,  0, 0, 0, 0, 1, 0, 4'hF, 2);
    tbl[11] = row(0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 2);
    tbl[12] = row(0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 2);
    tbl[13] = row(0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 2);
    // pending write to $0 never matches a $0 source
    tbl[14] = row(1,  0, 2,  0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 2);
    tbl[15] = row(1,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 2);
    // $5 in W and in M: youngest (M) wins
    tbl[16] = row(1,  5, 0,  0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 2);
    tbl[17] = row(1,  5, 0,  0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 2);
    tbl[18] = row(0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 2);
    tbl[19] = row(1,  6, 0,  5, 0,  5, 2, 0, 0, 2, 2, 4'hF, 2);
    // flush kills the E-entry load but leaves older entries alone
    tbl[20] = row(1,  7, 1,  0, 0,  0, 0, 1, 0, 0, 0, 4'hF, 2);
    tbl[21] = row(1,  0, 0,  7, 0,  6, 0, 0, 0, 0, 2, 4'hF, 2);
    // stall coinciding with flush still counts, then forward from W
    tbl[22] = row(1, 12, 2,  0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 2);
    tbl[23] = row(1, 13, 0, 12, 0,  0, 0, 1, 1, 0, 0, 4'hD, 2);
    tbl[24] = row(1, 13, 0, 12, 0,  0, 0, 0, 1, 0, 0, 4'hD, 3);
    tbl[25] = row(1, 13, 0, 12, 0,  0, 0, 0, 0, 3, 0, 4'hF, 4);

    rf_data  = {RF1, RF0};
    stg_data = {STG_W, STG_M, STG_E};
    reset    = 1'b0;
    d_valid  = 1'b0;
    d_a3     = 5'd0;
    d_tnew   = 2'd0;
    d_src    = 10'd0;
    d_tuse   = 4'd0;
    flush    = 1'b0;

    // Outputs while held in reset
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_sel", 32'(src_sel), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    #10;
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i]);
      sample(i);
      @(posedge clk);
      #1;
    end

    // Reset asserted in the middle of a stall
    d_valid = 1'b1; d_a3 = 5'd8; d_tnew = 2'd2; d_src = 10'd0; d_tuse = 4'd0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    d_a3 = 5'd0; d_tnew = 2'd0; d_src = {5'd0, 5'd8};
    #1;
    check("mid_pre_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    check("mid_stall_held", 32'(stall), 32'd1);
    check("mid_cnt", 32'(stall_cnt), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_cnt", 32'(stall_cnt), 32'd0);
    check("mid_rst_sel", 32'(src_sel), 32'd0);

    // Release: the very first edge afterwards loads the decoded writer
    @(negedge clk);
    reset = 1'b1;
    d_valid = 1'b1; d_a3 = 5'd8; d_tnew = 2'd2; d_src = 10'd0;
    @(posedge clk);
    #1;
    d_a3 = 5'd0; d_tnew = 2'd0; d_src = {5'd0, 5'd8};
    #1;
    check("rel_first_edge_stall", 32'(stall), 32'd1);
    check("rel_cnt", 32'(stall_cnt), 32'd0);
    d_valid = 1'b0; d_src = 10'd0;
    #20;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
